// File: rtl/jtopl_pkg.sv
// rtl/jtopl_pkg.sv - shared register map constants and strobe encoding for the OPL front end
package jtopl_pkg;

  // Register group bases as seen on the CPU bus
  localparam logic [7:0] REG_MULT  = 8'h20;
  localparam logic [7:0] REG_KSLTL = 8'h40;
  localparam logic [7:0] REG_ARDR  = 8'h60;
  localparam logic [7:0] REG_SLRR  = 8'h80;
  localparam logic [7:0] REG_FNUML = 8'hA0;
  localparam logic [7:0] REG_FNUMH = 8'hB0;
  localparam logic [7:0] REG_FBCON = 8'hC0;
  localparam logic [7:0] REG_RHY   = 8'hBD;
  localparam logic [7:0] REG_TIMA  = 8'h02;
  localparam logic [7:0] REG_TIMB  = 8'h03;
  localparam logic [7:0] REG_TCTL  = 8'h04;
  localparam logic [7:0] REG_CSM   = 8'h08;

  // Slots per scan; a strobe is held this many cen ticks
  localparam int SLOTS = 18;

  // Highest valid channel index within a channel register group
  localparam logic [3:0] MAX_CH = 4'd8;

  // One-hot field update strobe
  typedef enum logic [5:0] {
    STB_NONE  = 6'b000000,
    STB_MULT  = 6'b000001,
    STB_KSLTL = 6'b000010,
    STB_ARDR  = 6'b000100,
    STB_SLRR  = 6'b001000,
    STB_FNUM  = 6'b010000,
    STB_FBCON = 6'b100000
  } strobe_e;

  // Strobe hold state machine
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_e;

endpackage

// File: rtl/jtopl_mmr_dec.sv
// rtl/jtopl_mmr_dec.sv - combinational register number to strobe/group/subslot decoder
module jtopl_mmr_dec
  import jtopl_pkg::*;
(
  input  logic [7:0] addr,
  output strobe_e    strobe,
  output logic [1:0] group,
  output logic [2:0] sub,
  output logic       valid
);

  logic [4:0] op_off;
  logic [3:0] ch;
  logic [3:0] hi_nib;

  assign op_off = addr[4:0];
  assign ch     = addr[3:0];
  assign hi_nib = addr[7:4];

  // Operator groups use the 5-bit offset split as group:sub; channel groups map c to (c/3, c%3)
  always_comb begin
    strobe = STB_NONE;
    group  = 2'd0;
    sub    = 3'd0;
    valid  = 1'b0;
    case (addr[7:5])
      3'd1, 3'd2, 3'd3, 3'd4: begin
        if (op_off[2:0] <= 3'd5 && op_off[4:3] != 2'd3) begin
          valid = 1'b1;
          group = op_off[4:3];
          sub   = op_off[2:0];
          case (addr[7:5])
            3'd1:    strobe = STB_MULT;
            3'd2:    strobe = STB_KSLTL;
            3'd3:    strobe = STB_ARDR;
            default: strobe = STB_SLRR;
          endcase
        end
      end
      default: ;
    endcase
    if ((hi_nib == REG_FNUMH[7:4] || hi_nib == REG_FBCON[7:4]) && ch <= MAX_CH) begin
      valid = 1'b1;
      if (hi_nib == REG_FNUMH[7:4]) begin
        strobe = STB_FNUM;
      end else begin
        strobe = STB_FBCON;
      end
      case (ch)
        4'd0:    begin group = 2'd0; sub = 3'd0; end
        4'd1:    begin group = 2'd0; sub = 3'd1; end
        4'd2:    begin group = 2'd0; sub = 3'd2; end
        4'd3:    begin group = 2'd1; sub = 3'd0; end
        4'd4:    begin group = 2'd1; sub = 3'd1; end
        4'd5:    begin group = 2'd1; sub = 3'd2; end
        4'd6:    begin group = 2'd2; sub = 3'd0; end
        4'd7:    begin group = 2'd2; sub = 3'd1; end
        default: begin group = 2'd2; sub = 3'd2; end
      endcase
    end
  end

endmodule

// File: rtl/jtopl_mmr.sv
// rtl/jtopl_mmr.sv - CPU register front end: bus capture, decode, strobe hold and global registers
module jtopl_mmr #(
  parameter int SLOTS = jtopl_pkg::SLOTS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [7:0] din,
  input  logic       addr,
  input  logic       cs_n,
  input  logic       wr_n,
  output logic       busy,
  output logic       write,
  output logic [7:0] dout,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_fnum,
  output logic       up_fbcon,
  output logic [7:0] latch_fnum,
  output logic [7:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       flagen_A,
  output logic       flagen_B,
  output logic       clr_flags,
  output logic       csm,
  output logic       nts,
  output logic       am_dep,
  output logic       vib_dep,
  output logic       rhy_en,
  output logic [4:0] rhy_kon
);
  import jtopl_pkg::*;

  localparam logic [4:0] HOLD_LOAD = 5'(SLOTS - 1);

  // Bus capture
  logic       wr_act;
  logic       wr_act_q, wr_act_d;
  logic       ev_q, ev_d;
  logic       ev_a0_q, ev_a0_d;
  logic [7:0] ev_din_q, ev_din_d;
  logic [7:0] pend_addr_q, pend_addr_d;
  logic [7:0] act_addr_q, act_addr_d;
  logic [7:0] dout_q, dout_d;
  logic       write_q, write_d;
  logic       accept;

  // Global registers
  logic [7:0] latch_fnum_q, latch_fnum_d;
  logic [7:0] value_a_q, value_a_d;
  logic [7:0] value_b_q, value_b_d;
  logic       load_a_q, load_a_d;
  logic       load_b_q, load_b_d;
  logic       flagen_a_q, flagen_a_d;
  logic       flagen_b_q, flagen_b_d;
  logic       clr_q, clr_d;
  logic       csm_q, csm_d;
  logic       nts_q, nts_d;
  logic       am_q, am_d;
  logic       vib_q, vib_d;
  logic       rhy_en_q, rhy_en_d;
  logic [4:0] rhy_kon_q, rhy_kon_d;

  // Hold FSM
  hold_state_e state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  strobe_e     stb_q, stb_d;
  logic [5:0]  stb_bits;
  logic [1:0]  group_q, group_d;
  logic [2:0]  sub_q, sub_d;

  // Decoder view of the committed address
  strobe_e    dec_strobe;
  logic [1:0] dec_group;
  logic [2:0] dec_sub;
  logic       dec_valid;

  jtopl_mmr_dec u_dec (
    .addr   (act_addr_q),
    .strobe (dec_strobe),
    .group  (dec_group),
    .sub    (dec_sub),
    .valid  (dec_valid)
  );

  assign wr_act = !cs_n && !wr_n;

  // Bus edge detect, address/data latching and global register updates
  always_comb begin
    wr_act_d    = wr_act;
    ev_d        = wr_act && !wr_act_q;
    ev_a0_d     = addr;
    ev_din_d    = din;
    pend_addr_d = pend_addr_q;
    act_addr_d  = act_addr_q;
    dout_d      = dout_q;
    // A data write is refused while an update is in flight or still being decoded
    accept      = ev_q && ev_a0_q && !busy && !write_q;
    write_d     = accept;
    if (ev_q && !ev_a0_q) begin
      pend_addr_d = ev_din_q;
    end
    if (accept) begin
      dout_d     = ev_din_q;
      act_addr_d = pend_addr_q;
    end

    latch_fnum_d = latch_fnum_q;
    value_a_d    = value_a_q;
    value_b_d    = value_b_q;
    load_a_d     = load_a_q;
    load_b_d     = load_b_q;
    flagen_a_d   = flagen_a_q;
    flagen_b_d   = flagen_b_q;
    clr_d        = 1'b0;
    csm_d        = csm_q;
    nts_d        = nts_q;
    am_d         = am_q;
    vib_d        = vib_q;
    rhy_en_d     = rhy_en_q;
    rhy_kon_d    = rhy_kon_q;
    if (write_q) begin
      case (act_addr_q)
        REG_TIMA: value_a_d = dout_q;
        REG_TIMB: value_b_d = dout_q;
        REG_TCTL: begin
          // Flag reset writes leave the timer control bits untouched
          if (dout_q[7]) begin
            clr_d = 1'b1;
          end else begin
            load_a_d   = dout_q[0];
            load_b_d   = dout_q[1];
            flagen_a_d = !dout_q[6];
            flagen_b_d = !dout_q[5];
          end
        end
        REG_CSM: begin
          csm_d = dout_q[7];
          nts_d = dout_q[6];
        end
        REG_RHY: begin
          am_d      = dout_q[7];
          vib_d     = dout_q[6];
          rhy_en_d  = dout_q[5];
          rhy_kon_d = dout_q[4:0];
        end
        default: begin
          if (act_addr_q[7:4] == REG_FNUML[7:4] && act_addr_q[3:0] <= MAX_CH) begin
            latch_fnum_d = dout_q;
          end
        end
      endcase
    end
  end

  // Bus and global register flops
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_act_q     <= 1'b0;
      ev_q         <= 1'b0;
      ev_a0_q      <= 1'b0;
      ev_din_q     <= 8'd0;
      pend_addr_q  <= 8'd0;
      act_addr_q   <= 8'd0;
      dout_q       <= 8'd0;
      write_q      <= 1'b0;
      latch_fnum_q <= 8'd0;
      value_a_q    <= 8'd0;
      value_b_q    <= 8'd0;
      load_a_q     <= 1'b0;
      load_b_q     <= 1'b0;
      flagen_a_q   <= 1'b0;
      flagen_b_q   <= 1'b0;
      clr_q        <= 1'b0;
      csm_q        <= 1'b0;
      nts_q        <= 1'b0;
      am_q         <= 1'b0;
      vib_q        <= 1'b0;
      rhy_en_q     <= 1'b0;
      rhy_kon_q    <= 5'd0;
    end else begin
      wr_act_q     <= wr_act_d;
      ev_q         <= ev_d;
      ev_a0_q      <= ev_a0_d;
      ev_din_q     <= ev_din_d;
      pend_addr_q  <= pend_addr_d;
      act_addr_q   <= act_addr_d;
      dout_q       <= dout_d;
      write_q      <= write_d;
      latch_fnum_q <= latch_fnum_d;
      value_a_q    <= value_a_d;
      value_b_q    <= value_b_d;
      load_a_q     <= load_a_d;
      load_b_q     <= load_b_d;
      flagen_a_q   <= flagen_a_d;
      flagen_b_q   <= flagen_b_d;
      clr_q        <= clr_d;
      csm_q        <= csm_d;
      nts_q        <= nts_d;
      am_q         <= am_d;
      vib_q        <= vib_d;
      rhy_en_q     <= rhy_en_d;
      rhy_kon_q    <= rhy_kon_d;
    end
  end

  // Hold FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      stb_q   <= STB_NONE;
      group_q <= 2'd0;
      sub_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      group_q <= group_d;
      sub_q   <= sub_d;
    end
  end

  // Hold FSM next state: one full slot scan per strobed write, cen during the write pulse is not counted
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stb_d   = stb_q;
    group_d = group_q;
    sub_d   = sub_q;
    case (state_q)
      ST_IDLE: begin
        if (write_q && dec_valid) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
          stb_d   = dec_strobe;
          group_d = dec_group;
          sub_d   = dec_sub;
        end
      end
      ST_HOLD: begin
        if (cen) begin
          if (cnt_q == 5'd0) begin
            state_d = ST_IDLE;
            stb_d   = STB_NONE;
            group_d = 2'd0;
            sub_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stb_bits = stb_q;

  // Hold FSM outputs: strobes are gated by the HOLD state so busy and strobe share one window
  always_comb begin
    busy      = (state_q == ST_HOLD);
    up_mult   = busy && stb_bits[0];
    up_ksl_tl = busy && stb_bits[1];
    up_ar_dr  = busy && stb_bits[2];
    up_sl_rr  = busy && stb_bits[3];
    up_fnum   = busy && stb_bits[4];
    up_fbcon  = busy && stb_bits[5];
    sel_group = group_q;
    sel_sub   = sub_q;
  end

  assign write      = write_q;
  assign dout       = dout_q;
  assign latch_fnum = latch_fnum_q;
  assign value_A    = value_a_q;
  assign value_B    = value_b_q;
  assign load_A     = load_a_q;
  assign load_B     = load_b_q;
  assign flagen_A   = flagen_a_q;
  assign flagen_B   = flagen_b_q;
  assign clr_flags  = clr_q;
  assign csm        = csm_q;
  assign nts        = nts_q;
  assign am_dep     = am_q;
  assign vib_dep    = vib_q;
  assign rhy_en     = rhy_en_q;
  assign rhy_kon    = rhy_kon_q;

endmodule

// File: tb/tb_jtopl_mmr.sv
// tb/tb_jtopl_mmr.sv - directed scoreboard bench for the OPL register front end
module tb_jtopl_mmr;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen = 1'b0;
  logic [7:0] din;
  logic       addr;
  logic       cs_n;
  logic       wr_n;
  logic       busy, write;
  logic [7:0] dout;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnum, up_fbcon;
  logic [7:0] latch_fnum, value_A, value_B;
  logic       load_A, load_B, flagen_A, flagen_B, clr_flags;
  logic       csm, nts, am_dep, vib_dep, rhy_en;
  logic [4:0] rhy_kon;

  jtopl_mmr #(.SLOTS(18)) dut (
    .clk(clk), .rst(rst), .cen(cen), .din(din), .addr(addr), .cs_n(cs_n), .wr_n(wr_n),
    .busy(busy), .write(write), .dout(dout), .sel_group(sel_group), .sel_sub(sel_sub),
    .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr), .up_sl_rr(up_sl_rr),
    .up_fnum(up_fnum), .up_fbcon(up_fbcon), .latch_fnum(latch_fnum),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .flagen_A(flagen_A), .flagen_B(flagen_B), .clr_flags(clr_flags),
    .csm(csm), .nts(nts), .am_dep(am_dep), .vib_dep(vib_dep), .rhy_en(rhy_en),
    .rhy_kon(rhy_kon)
  );

  always #5 clk = ~clk;

  // cen one clk in three, changed just after the rising edge
  int cen_div = 0;
  always @(posedge clk) begin
    #1;
    cen_div = (cen_div == 2) ? 0 : cen_div + 1;
    cen = (cen_div == 0);
  end

  localparam logic [5:0] S_MULT = 6'b000001, S_KSL = 6'b000010, S_ARDR = 6'b000100;
  localparam logic [5:0] S_FNUM = 6'b010000;

  typedef struct {
    logic [5:0] stb;
    logic [1:0] grp;
    logic [2:0] sub;
    logic [7:0] dout;
    int         len;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int checks = 0;
  int errors = 0;
  int write_cnt = 0, write_run = 0;
  int clr_cnt = 0, clr_run = 0;
  int cen_seen = 0;
  logic busy_prev = 1'b0;
  logic [5:0] stb_now;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [5:0] s, input logic [1:0] g, input logic [2:0] u,
                          input logic [7:0] d, input int len);
    exp_t e;
    e.stb = s; e.grp = g; e.sub = u; e.dout = d; e.len = len;
    sb_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard when a hold window opens and checks it while and when it closes
  always @(negedge clk) begin
    stb_now = {up_fbcon, up_fnum, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};
    if (busy && !busy_prev) begin
      check("busy_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        cur = sb_q.pop_front();
        check("win_strobe", 32'(stb_now), 32'(cur.stb));
        check("win_group", 32'(sel_group), 32'(cur.grp));
        check("win_sub", 32'(sel_sub), 32'(cur.sub));
        check("win_dout", 32'(dout), 32'(cur.dout));
      end else begin
        cur.len = 0;
      end
      cen_seen = 0;
    end
    if (busy) begin
      check("onehot", 32'($countones(stb_now)), 32'd1);
      check("stb_stable", 32'(stb_now), 32'(cur.stb));
      check("grp_stable", 32'(sel_group), 32'(cur.grp));
      check("sub_stable", 32'(sel_sub), 32'(cur.sub));
      if (cen) cen_seen++;
    end else begin
      check("stb_idle", 32'(stb_now), 32'd0);
    end
    if (!busy && busy_prev && cur.len != 0) begin
      check("hold_len", 32'(cen_seen), 32'(cur.len));
    end
    busy_prev = busy;
    if (write) begin
      if (write_run == 0) write_cnt++;
      write_run++;
    end else begin
      if (write_run != 0) check("write_width", 32'(write_run), 32'd1);
      write_run = 0;
    end
    if (clr_flags) begin
      if (clr_run == 0) clr_cnt++;
      clr_run++;
    end else begin
      if (clr_run != 0) check("clr_width", 32'(clr_run), 32'd1);
      clr_run = 0;
    end
  end

  task automatic bus_wr(input logic a0, input logic [7:0] d);
    @(negedge clk);
    addr = a0; din = d; cs_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(negedge clk);
    wr_n = 1'b1; cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int w0, c0, n;
    logic [7:0] bad_addr [4];
    bad_addr[0] = 8'h26; bad_addr[1] = 8'h38; bad_addr[2] = 8'hA9; bad_addr[3] = 8'hC9;
    rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; addr = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_sel", 32'({sel_group, sel_sub}), 32'd0);
    check("rst_flagen", 32'({flagen_A, flagen_B}), 32'd0);
    check("rst_rhy", 32'({am_dep, vib_dep, rhy_en, rhy_kon}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Operator write 0x63 <- 0xF2
    push_exp(S_ARDR, 2'd0, 3'd3, 8'hF2, 18);
    bus_wr(1'b0, 8'h63);
    w0 = write_cnt;
    bus_wr(1'b1, 8'hF2);
    check("ardr_write_cnt", 32'(write_cnt), 32'(w0 + 1));
    check("ardr_dout", 32'(dout), 32'hF2);
    check("ardr_busy", 32'(busy), 32'd1);
    wait_idle();

    // fnum low then high
    bus_wr(1'b0, 8'hA4);
    bus_wr(1'b1, 8'h81);
    check("fnuml_latch", 32'(latch_fnum), 32'h81);
    check("fnuml_busy", 32'(busy), 32'd0);
    push_exp(S_FNUM, 2'd1, 3'd1, 8'h31, 18);
    bus_wr(1'b0, 8'hB4);
    bus_wr(1'b1, 8'h31);
    check("fnum_busy", 32'(busy), 32'd1);

    // Writes during busy: address is taken, data is refused
    w0 = write_cnt;
    bus_wr(1'b0, 8'h45);
    bus_wr(1'b1, 8'h10);
    check("busy_ignored_write", 32'(write_cnt), 32'(w0));
    check("busy_ignored_dout", 32'(dout), 32'h31);
    check("busy_still_fnum", 32'(up_fnum), 32'd1);
    wait_idle();
    push_exp(S_KSL, 2'd0, 3'd5, 8'h22, 18);
    bus_wr(1'b1, 8'h22);
    check("ksl_busy", 32'(busy), 32'd1);
    wait_idle();

    // Invalid and out of range addresses
    for (int i = 0; i < 4; i++) begin
      w0 = write_cnt;
      bus_wr(1'b0, bad_addr[i]);
      bus_wr(1'b1, 8'h5A);
      check("inv_write_cnt", 32'(write_cnt), 32'(w0 + 1));
      check("inv_busy", 32'(busy), 32'd0);
    end
    check("inv_latch_keep", 32'(latch_fnum), 32'h81);

    // Global registers
    bus_wr(1'b0, 8'hBD);
    bus_wr(1'b1, 8'hE5);
    check("rhy_am", 32'(am_dep), 32'd1);
    check("rhy_vib", 32'(vib_dep), 32'd1);
    check("rhy_en", 32'(rhy_en), 32'd1);
    check("rhy_kon", 32'(rhy_kon), 32'h05);
    c0 = clr_cnt;
    bus_wr(1'b0, 8'h04);
    bus_wr(1'b1, 8'h80);
    check("clr_pulse", 32'(clr_cnt), 32'(c0 + 1));
    check("clr_loads", 32'({load_A, load_B}), 32'd0);
    bus_wr(1'b1, 8'h23);
    check("tctl_loads", 32'({load_A, load_B}), 32'b11);
    check("tctl_flagen", 32'({flagen_A, flagen_B}), 32'b10);
    check("tctl_no_clr", 32'(clr_cnt), 32'(c0 + 1));
    bus_wr(1'b0, 8'h02);
    bus_wr(1'b1, 8'h5A);
    check("value_A", 32'(value_A), 32'h5A);
    bus_wr(1'b0, 8'h03);
    bus_wr(1'b1, 8'hA5);
    check("value_B", 32'(value_B), 32'hA5);
    bus_wr(1'b0, 8'h08);
    bus_wr(1'b1, 8'hC0);
    check("csm_nts", 32'({csm, nts}), 32'b11);

    // Reset in the middle of a hold window, counter at 9
    push_exp(S_MULT, 2'd1, 3'd5, 8'h77, 0);
    bus_wr(1'b0, 8'h2D);
    bus_wr(1'b1, 8'h77);
    n = 0;
    while (cen_seen < 8 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("mid_hold_reach", 32'(cen_seen), 32'd8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_strobes", 32'({up_fbcon, up_fnum, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult}), 32'd0);
    check("abort_timers", 32'({value_A, value_B}), 32'd0);
    check("abort_tctl", 32'({load_A, load_B, flagen_A, flagen_B}), 32'd0);
    check("abort_glob", 32'({csm, nts, am_dep, vib_dep, rhy_en, rhy_kon}), 32'd0);
    check("abort_latch", 32'(latch_fnum), 32'd0);
    check("abort_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Pending address cleared: a bare data write lands on unmapped 0x00
    w0 = write_cnt;
    bus_wr(1'b1, 8'h55);
    check("post_rst_bare_write", 32'(write_cnt), 32'(w0 + 1));
    check("post_rst_bare_busy", 32'(busy), 32'd0);
    push_exp(S_ARDR, 2'd0, 3'd3, 8'hF2, 18);
    bus_wr(1'b0, 8'h63);
    bus_wr(1'b1, 8'hF2);
    check("post_rst_busy", 32'(busy), 32'd1);
    wait_idle();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
